aes_dec_ctrl: RTL

Iterative sequencer for the AES-128 inverse cipher. It time-shares one dec_round datapath instance (add_rkey → inv_mix_cols → inv_shift_rows → inv_sub_bytes) across all rounds and drives the round-key store address. It performs the closing AddRoundKey(key 0) itself. It sits between the block-level valid/ready input stream and the plaintext output stream.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_rnd_timer.sv | 44 ++++
 rtl/aes_dec_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 inverse-cipher controller slice.
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_BLK_W  = 128;
  localparam int AES_ADDR_W = 4;
  localparam int AES_LAT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } dec_ctrl_state_t;

endpackage

// File: rtl/aes_rnd_timer.sv
// Round counter (NR down to 1) paired with a per-round latency counter.
// step marks the cycle in which the datapath result is valid for capture.
module aes_rnd_timer
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int RND_LAT = 2,
  parameter int ADDR_W  = AES_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic [ADDR_W-1:0] rnd,
  output logic              step,
  output logic              last
);

  localparam logic [AES_LAT_W-1:0] LAT_MAX  = AES_LAT_W'(RND_LAT - 1);
  localparam logic [ADDR_W-1:0]    RND_INIT = ADDR_W'(NR);

  logic [AES_LAT_W-1:0] lat_cnt;

  assign step = en && (lat_cnt == LAT_MAX);
  assign last = step && (rnd == ADDR_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd     <= RND_INIT;
      lat_cnt <= '0;
    end else if (start) begin
      rnd     <= RND_INIT;
      lat_cnt <= '0;
    end else if (step) begin
      lat_cnt <= '0;
      if (rnd != '0) rnd <= rnd - ADDR_W'(1);
    end else if (en) begin
      lat_cnt <= lat_cnt + AES_LAT_W'(1);
    end
  end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 inverse-cipher sequencer: time-shares one dec_round
// datapath over all rounds and applies the closing AddRoundKey(key 0) itself.
module aes_dec_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int RND_LAT = 2,
  parameter int ADDR_W  = AES_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [ADDR_W-1:0]    key_addr,
  input  logic [AES_BLK_W-1:0] rkey,
  output logic [AES_BLK_W-1:0] rnd_din,
  output logic [ADDR_W-1:0]    rnd_addr,
  output logic                 rnd_mix_bypass,
  input  logic [AES_BLK_W-1:0] rnd_dout,
  output logic                 busy
);

  dec_ctrl_state_t      state;
  logic [AES_BLK_W-1:0] blk_q;
  logic [ADDR_W-1:0]    rnd;
  logic                 step;
  logic                 last;
  logic                 start;
  logic                 in_issue;

  assign in_issue = (state == ISSUE);
  assign start    = (state == IDLE) && in_valid && in_ready;

  aes_rnd_timer #(
    .NR      (NR),
    .RND_LAT (RND_LAT),
    .ADDR_W  (ADDR_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .en    (in_issue),
    .rnd   (rnd),
    .step  (step),
    .last  (last)
  );

  // Datapath drive is zero outside ISSUE; FINAL reads key 0 for the closing XOR.
  assign key_addr       = in_issue ? rnd : '0;
  assign rnd_addr       = key_addr;
  assign rnd_din        = in_issue ? blk_q : '0;
  assign rnd_mix_bypass = in_issue && (rnd == ADDR_W'(NR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            blk_q    <= in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (step) begin
            blk_q <= rnd_dout;
            if (last) state <= FINAL;
          end
        end
        FINAL: begin
          out_data  <= blk_q ^ rkey;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
